// File: rtl/cloth_pkg.sv
// Shared definitions for the cloth physics frame sequencer.
package cloth_pkg;
  localparam int DEF_N_LINKS = 16;
  localparam int DEF_N_ITER  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VERLET,
    ST_CONSTRAIN,
    ST_FIX,
    ST_DONE
  } seq_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/physics_step_sequencer_if.sv
// Frame control and solver-facing link handshake of the step sequencer.
interface physics_step_sequencer_if #(
  parameter int IDX_W  = 4,
  parameter int ITER_W = 2
) ();
  logic              start;
  logic              solver_ready;
  logic              verlet_state;
  logic              fix_constraint_state;
  logic              link_valid;
  logic [IDX_W-1:0]  link_idx;
  logic [ITER_W-1:0] iter_cnt;
  logic              busy;
  logic              done;

  modport master (
    input  start, solver_ready,
    output verlet_state, fix_constraint_state, link_valid, link_idx, iter_cnt, busy, done
  );

  modport slave (
    output start, solver_ready,
    input  verlet_state, fix_constraint_state, link_valid, link_idx, iter_cnt, busy, done
  );
endinterface

// File: rtl/physics_step_sequencer_link_iter_counter.sv
// Nested link/iteration wrap counter; last flags the final link of the final pass.
module link_iter_counter #(
  parameter int N_LINKS = 16,
  parameter int N_ITER  = 4,
  parameter int IDX_W   = 4,
  parameter int ITER_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [IDX_W-1:0]  link_idx,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              last
);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_LINKS - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);

  logic idx_wrap;
  assign idx_wrap = (link_idx == LAST_IDX);
  assign last     = idx_wrap && (iter_cnt == LAST_ITER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      link_idx <= '0;
      iter_cnt <= '0;
    end else if (clear) begin
      link_idx <= '0;
      iter_cnt <= '0;
    end else if (advance) begin
      if (idx_wrap) begin
        link_idx <= '0;
        // the final pass also wraps, so the counter reads 0 once CONSTRAIN ends
        iter_cnt <= (iter_cnt == LAST_ITER) ? '0 : iter_cnt + 1'b1;
      end else begin
        link_idx <= link_idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/physics_step_sequencer.sv
// Per-frame sequencer: verlet integrate, N_ITER constraint passes over N_LINKS links, pin fix.
module physics_step_sequencer
  import cloth_pkg::*;
#(
  parameter int N_LINKS = DEF_N_LINKS,
  parameter int N_ITER  = DEF_N_ITER,
  parameter int IDX_W   = clog2_min1(N_LINKS),
  parameter int ITER_W  = clog2_min1(N_ITER)
) (
  input logic clk,
  input logic reset,
  physics_step_sequencer_if.master bus
);
  seq_state_e state, state_nxt;
  logic       xfer;
  logic       last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (bus.start) state_nxt = ST_VERLET;
      ST_VERLET:    state_nxt = ST_CONSTRAIN;
      ST_CONSTRAIN: if (xfer && last) state_nxt = ST_FIX;
      ST_FIX:       state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign xfer = (state == ST_CONSTRAIN) && bus.solver_ready;

  // held cleared outside CONSTRAIN so every pass set starts at 0,0 and idle reads 0
  link_iter_counter #(
    .N_LINKS(N_LINKS),
    .N_ITER (N_ITER),
    .IDX_W  (IDX_W),
    .ITER_W (ITER_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_CONSTRAIN),
    .advance (xfer),
    .link_idx(bus.link_idx),
    .iter_cnt(bus.iter_cnt),
    .last    (last)
  );

  assign bus.verlet_state         = (state == ST_VERLET);
  assign bus.link_valid           = (state == ST_CONSTRAIN);
  assign bus.fix_constraint_state = (state == ST_FIX);
  assign bus.done                 = (state == ST_DONE);
  assign bus.busy                 = (state != ST_IDLE);
endmodule

// File: tb/tb_physics_step_sequencer.sv
// Directed checks of the step sequencer at N_LINKS=4/N_ITER=2 and the 1/1 corner.
module tb_physics_step_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  physics_step_sequencer_if #(.IDX_W(2), .ITER_W(1)) bus_a ();
  physics_step_sequencer_if #(.IDX_W(1), .ITER_W(1)) bus_b ();

  physics_step_sequencer #(.N_LINKS(4), .N_ITER(2), .IDX_W(2), .ITER_W(1)) dut_a (
    .clk(clk), .reset(rst_n), .bus(bus_a.master)
  );
  physics_step_sequencer #(.N_LINKS(1), .N_ITER(1), .IDX_W(1), .ITER_W(1)) dut_b (
    .clk(clk), .reset(rst_n), .bus(bus_b.master)
  );

  // status word {busy, verlet, fix, link_valid, done}
  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_VER  = 5'b11000;
  localparam logic [4:0] S_FIX  = 5'b10100;
  localparam logic [4:0] S_CON  = 5'b10010;
  localparam logic [4:0] S_DONE = 5'b10001;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk_st(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] st_a();
    return {bus_a.busy, bus_a.verlet_state, bus_a.fix_constraint_state, bus_a.link_valid, bus_a.done};
  endfunction

  function automatic logic [4:0] st_b();
    return {bus_b.busy, bus_b.verlet_state, bus_b.fix_constraint_state, bus_b.link_valid, bus_b.done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers;
    int viol;
    int nb;
    logic [4:0] exp_b [1:5];
    exp_b = '{S_VER, S_CON, S_FIX, S_DONE, S_IDLE};

    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.solver_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.solver_ready = 1'b0;
    #2;
    chk_st("rst_st_a", st_a(), S_IDLE);
    chk_v("rst_idx_a", 32'(bus_a.link_idx), 0);
    chk_v("rst_iter_a", 32'(bus_a.iter_cnt), 0);
    chk_st("rst_st_b", st_b(), S_IDLE);
    #20 rst_n = 1'b1;
    step();
    repeat (2) step();
    chk_st("idle_nostart", st_a(), S_IDLE);

    // full frame with solver always ready
    bus_a.solver_ready = 1'b1;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    chk_st("f1_c1", st_a(), S_VER);
    for (int c = 2; c <= 9; c++) begin
      step();
      chk_st($sformatf("f1_c%0d_st", c), st_a(), S_CON);
      chk_v($sformatf("f1_c%0d_idx", c), 32'(bus_a.link_idx), 32'((c - 2) % 4));
      chk_v($sformatf("f1_c%0d_iter", c), 32'(bus_a.iter_cnt), 32'((c - 2) / 4));
    end
    step(); chk_st("f1_c10_fix", st_a(), S_FIX);
    chk_v("f1_c10_idx", 32'(bus_a.link_idx), 0);
    step(); chk_st("f1_c11_done", st_a(), S_DONE);
    step(); chk_st("f1_c12_idle", st_a(), S_IDLE);

    // stall at link 2 of pass 1
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    repeat (7) step();
    bus_a.solver_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_st($sformatf("stall%0d_st", i), st_a(), S_CON);
      chk_v($sformatf("stall%0d_idx", i), 32'(bus_a.link_idx), 2);
      chk_v($sformatf("stall%0d_iter", i), 32'(bus_a.iter_cnt), 1);
      step();
    end
    bus_a.solver_ready = 1'b1;
    chk_v("stall_rel_idx", 32'(bus_a.link_idx), 2);
    step();
    chk_v("stall_next_idx", 32'(bus_a.link_idx), 3);
    chk_v("stall_next_iter", 32'(bus_a.iter_cnt), 1);
    step(); chk_st("stall_fix", st_a(), S_FIX);
    step(); chk_st("stall_done", st_a(), S_DONE);
    step(); chk_st("stall_idle", st_a(), S_IDLE);

    // start held high: only accepted from IDLE, one idle cycle between frames
    bus_a.start = 1'b1;
    step(); chk_st("hold_c1", st_a(), S_VER);
    step(); chk_st("hold_c2", st_a(), S_CON);
    chk_v("hold_c2_idx", 32'(bus_a.link_idx), 0);
    repeat (8) step(); chk_st("hold_c10", st_a(), S_FIX);
    step(); chk_st("hold_c11", st_a(), S_DONE);
    step(); chk_st("hold_c12", st_a(), S_IDLE);
    step(); chk_st("hold_c13", st_a(), S_VER);
    bus_a.start = 1'b0;
    for (int k = 0; k < 40 && !bus_a.done; k++) step();
    chk_st("hold_f2_done", st_a(), S_DONE);
    step(); chk_st("hold_f2_idle", st_a(), S_IDLE);

    // asynchronous reset mid-CONSTRAIN
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    repeat (4) step();
    chk_v("pre_rst_idx", 32'(bus_a.link_idx), 3);
    #2 rst_n = 1'b0;
    #1;
    chk_st("arst_st", st_a(), S_IDLE);
    chk_v("arst_idx", 32'(bus_a.link_idx), 0);
    chk_v("arst_iter", 32'(bus_a.iter_cnt), 0);
    #20 rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk_st($sformatf("post_rst%0d_st", i), st_a(), S_IDLE);
      chk_v($sformatf("post_rst%0d_idx", i), 32'(bus_a.link_idx), 0);
    end

    // random solver_ready
    xfers = 0;
    viol = 0;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int k = 0; k < 200 && !bus_a.done; k++) begin
      bus_a.solver_ready = 1'($urandom_range(0, 1));
      if ($countones({bus_a.verlet_state, bus_a.fix_constraint_state, bus_a.link_valid, bus_a.done}) > 1)
        viol++;
      if (bus_a.link_valid && bus_a.solver_ready) begin
        chk_v($sformatf("rnd_idx%0d", xfers), 32'(bus_a.link_idx), 32'(xfers % 4));
        chk_v($sformatf("rnd_iter%0d", xfers), 32'(bus_a.iter_cnt), 32'(xfers / 4));
        xfers++;
      end
      step();
    end
    chk_st("rnd_done", st_a(), S_DONE);
    chk_v("rnd_xfers", 32'(xfers), 8);
    chk_v("rnd_excl", 32'(viol), 0);
    bus_a.solver_ready = 1'b1;
    step();

    // degenerate 1x1 configuration
    nb = 0;
    bus_b.solver_ready = 1'b1;
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk_st($sformatf("b_c%0d", c), st_b(), exp_b[c]);
      if (bus_b.link_valid) begin
        chk_v("b_idx", 32'(bus_b.link_idx), 0);
        nb++;
      end
      step();
    end
    chk_v("b_xfers", 32'(nb), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
